// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
// systolic_pkg : shared FSM state type and saturating-accumulate helpers
// Revision 1.0
// ============================================================================
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Working width of sat_add; callers narrow the result to their own ACC_W.
  localparam int SAT_ARG_W = 64;

  function automatic bit acc_width_ok(input int w, input int acc_w);
    return acc_w >= 2 * w;
  endfunction

  // One extra bit of headroom catches the overflow before clamping to acc_w.
  function automatic logic signed [SAT_ARG_W-1:0] sat_add(
    input logic signed [SAT_ARG_W-1:0] acc,
    input logic signed [SAT_ARG_W-1:0] addend,
    input int                          acc_w,
    input logic                        sat
  );
    logic signed [SAT_ARG_W:0] sum;
    logic signed [SAT_ARG_W:0] hi;
    logic signed [SAT_ARG_W:0] lo;
    logic signed [SAT_ARG_W:0] one;
    one = 1;
    sum = {acc[SAT_ARG_W-1], acc} + {addend[SAT_ARG_W-1], addend};
    hi  = (one <<< (acc_w - 1)) - one;
    lo  = -(one <<< (acc_w - 1));
    if (sat && (sum > hi)) begin
      sum = hi;
    end else if (sat && (sum < lo)) begin
      sum = lo;
    end
    return sum[SAT_ARG_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/systolic_mac_lane.sv
`default_nettype none
// ============================================================================
// systolic_mac_lane : one skew stage plus a signed multiply-accumulate
// Revision 1.0
// ============================================================================
module systolic_mac_lane
  import systolic_pkg::*;
#(
  parameter int W      = 8,
  parameter int ACC_W  = 16,
  parameter int N_MACS = 4,
  parameter int LANE   = 0,
  parameter int SAT    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  zero,
  input  logic                  beat_valid,
  input  logic [W-1:0]          beat_a,
  input  logic [N_MACS*W-1:0]   beat_w,
  output logic                  stage_valid,
  output logic [W-1:0]          stage_a,
  output logic [N_MACS*W-1:0]   stage_w,
  output logic [ACC_W-1:0]      acc,
  output logic                  updated
);

  logic signed [2*W-1:0] prod;
  logic [ACC_W-1:0]      acc_next;

  assign prod     = $signed(stage_a) * $signed(stage_w[LANE*W +: W]);
  assign acc_next = ACC_W'(sat_add(SAT_ARG_W'($signed(acc)), SAT_ARG_W'(prod),
                                   ACC_W, SAT != 0));

  // The whole weight bus rides the chain so later lanes find their slice.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stage_valid <= 1'b0;
      stage_a     <= '0;
      stage_w     <= '0;
      acc         <= '0;
      updated     <= 1'b0;
    end else begin
      stage_valid <= beat_valid;
      stage_a     <= beat_a;
      stage_w     <= beat_w;
      updated     <= 1'b0;
      if (zero) begin
        acc <= '0;
      end else if (stage_valid) begin
        acc     <= acc_next;
        updated <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/systolic_layer_engine.sv
`default_nettype none
// ============================================================================
// systolic_layer_engine : sequencer and skewed MAC array for y[j] = sum a*w[j]
// Revision 1.0
// ============================================================================
module systolic_layer_engine
  import systolic_pkg::*;
#(
  parameter int W      = 8,
  parameter int ACC_W  = 16,
  parameter int N_MACS = 4,
  parameter int LEN_W  = 8,
  parameter int SAT    = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [LEN_W-1:0]          len,
  input  logic                      keep_acc,
  input  logic                      clear_acc,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [W-1:0]              a_in,
  input  logic [N_MACS*W-1:0]       w_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N_MACS*ACC_W-1:0]   acc_out,
  output logic [N_MACS-1:0]         lane_valid,
  output logic                      busy
);

  localparam int DRAIN_W  = $clog2(N_MACS + 1);
  localparam bit ACC_W_OK = acc_width_ok(W, ACC_W);

  if (!ACC_W_OK) begin : g_width_check
    $error("systolic_layer_engine: ACC_W must be at least 2*W");
  end

  state_t             state;
  state_t             state_next;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   beat_cnt;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               xfer;
  logic               last_beat;
  logic               drain_done;
  logic               zero_acc;

  assign in_ready   = (state == RUN);
  assign out_valid  = (state == DONE);
  assign busy       = (state != IDLE);
  assign xfer       = in_valid & in_ready;
  assign last_beat  = xfer && (beat_cnt == len_q - LEN_W'(1));
  assign drain_done = (drain_cnt == DRAIN_W'(N_MACS - 1));
  // A start in the same cycle overrides clear_acc; keep_acc decides then.
  assign zero_acc   = (state == IDLE) && (start ? !keep_acc : clear_acc);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (len == '0) ? DONE : RUN;
      RUN:     if (last_beat) state_next = DRAIN;
      DRAIN:   if (drain_done) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      len_q     <= '0;
      beat_cnt  <= '0;
      drain_cnt <= '0;
    end else begin
      if ((state == IDLE) && start) begin
        len_q    <= len;
        beat_cnt <= '0;
      end else if (xfer) begin
        beat_cnt <= beat_cnt + LEN_W'(1);
      end
      if (state == DRAIN) drain_cnt <= drain_cnt + DRAIN_W'(1);
      else                drain_cnt <= '0;
    end
  end

  logic                chain_valid [N_MACS];
  logic [W-1:0]        chain_a     [N_MACS];
  logic [N_MACS*W-1:0] chain_w     [N_MACS];

  for (genvar j = 0; j < N_MACS; j++) begin : g_lane
    logic                beat_v;
    logic [W-1:0]        beat_a;
    logic [N_MACS*W-1:0] beat_w;

    if (j == 0) begin : g_head
      assign beat_v = xfer;
      assign beat_a = a_in;
      assign beat_w = w_in;
    end else begin : g_tail
      assign beat_v = chain_valid[j-1];
      assign beat_a = chain_a[j-1];
      assign beat_w = chain_w[j-1];
    end

    systolic_mac_lane #(
      .W      (W),
      .ACC_W  (ACC_W),
      .N_MACS (N_MACS),
      .LANE   (j),
      .SAT    (SAT)
    ) u_lane (
      .clk         (clk),
      .rst         (rst),
      .zero        (zero_acc),
      .beat_valid  (beat_v),
      .beat_a      (beat_a),
      .beat_w      (beat_w),
      .stage_valid (chain_valid[j]),
      .stage_a     (chain_a[j]),
      .stage_w     (chain_w[j]),
      .acc         (acc_out[j*ACC_W +: ACC_W]),
      .updated     (lane_valid[j])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_systolic_layer_engine.sv
`default_nettype none
// ============================================================================
// tb_systolic_layer_engine : directed checks of the systolic engine
// Revision 1.0
// ============================================================================
module tb_systolic_layer_engine;

  localparam int W     = 8;
  localparam int ACC_W = 16;
  localparam int N     = 4;
  localparam int LEN_W = 8;

  localparam logic [N*W-1:0]     W_BASIC = {8'd4, 8'd3, 8'd2, 8'd1};
  localparam logic [N*W-1:0]     W_MAX   = {4{8'd127}};
  localparam logic [N*ACC_W-1:0] ACC_ONE = {16'd24, 16'd18, 16'd12, 16'd6};
  localparam logic [N*ACC_W-1:0] ACC_TWO = {16'd48, 16'd36, 16'd24, 16'd12};
  localparam logic [N*ACC_W-1:0] ACC_SAT = {4{16'h7FFF}};
  localparam logic [N*ACC_W-1:0] ACC_WRP = {4{16'hFC04}};

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [LEN_W-1:0]   len;
  logic               keep_acc;
  logic               clear_acc;
  logic               in_valid;
  logic [W-1:0]       a_in;
  logic [N*W-1:0]     w_in;
  logic               out_ready;
  logic               in_ready,   in_ready_w;
  logic               out_valid,  out_valid_w;
  logic               busy,       busy_w;
  logic [N*ACC_W-1:0] acc_out,    acc_out_w;
  logic [N-1:0]       lane_valid, lane_valid_w;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  systolic_layer_engine #(.W(W), .ACC_W(ACC_W), .N_MACS(N), .LEN_W(LEN_W), .SAT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .keep_acc(keep_acc),
    .clear_acc(clear_acc), .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in),
    .w_in(w_in), .out_valid(out_valid), .out_ready(out_ready), .acc_out(acc_out),
    .lane_valid(lane_valid), .busy(busy)
  );

  systolic_layer_engine #(.W(W), .ACC_W(ACC_W), .N_MACS(N), .LEN_W(LEN_W), .SAT(0)) dut_wrap (
    .clk(clk), .rst(rst), .start(start), .len(len), .keep_acc(keep_acc),
    .clear_acc(clear_acc), .in_valid(in_valid), .in_ready(in_ready_w), .a_in(a_in),
    .w_in(w_in), .out_valid(out_valid_w), .out_ready(out_ready), .acc_out(acc_out_w),
    .lane_valid(lane_valid_w), .busy(busy_w)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [LEN_W-1:0] l, input logic keep);
    start = 1'b1; len = l; keep_acc = keep;
    step();
    start = 1'b0; keep_acc = 1'b0;
  endtask

  task automatic feed_beat(input logic [W-1:0] a, input logic [N*W-1:0] w);
    in_valid = 1'b1; a_in = a; w_in = w;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (out_valid !== 1'b1 && cycles < 50) begin
      step();
      cycles++;
    end
  endtask

  task automatic finish_job();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step(); step();
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (lane_valid !== 4'b0) begin n_bad++; $display("FAIL reset_lane_valid: got %b want 0000", lane_valid); end
    n_cmp++; if (acc_out !== '0) begin n_bad++; $display("FAIL reset_acc: got %h want 0", acc_out); end
    rst = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int c;
    start_job(8'd3, 1'b0);
    n_cmp++; if (busy !== 1'b1 || in_ready !== 1'b1) begin n_bad++; $display("FAIL basic_run_state: got busy=%b in_ready=%b want 1 1", busy, in_ready); end
    for (int k = 1; k <= 3; k++) feed_beat(W'(k), W_BASIC);
    n_cmp++; if (lane_valid !== 4'b0011) begin n_bad++; $display("FAIL basic_lane_valid: got %b want 0011", lane_valid); end
    wait_done(c);
    n_cmp++; if (c + 4 !== 8) begin n_bad++; $display("FAIL basic_latency: got %0d want 8", c + 4); end
    n_cmp++; if (acc_out !== ACC_ONE) begin n_bad++; $display("FAIL basic_acc: got %h want %h", acc_out, ACC_ONE); end
    finish_job();
  endtask

  task automatic test_bubbles_backpressure();
    int c;
    start_job(8'd3, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      in_valid = 1'b0;
      step();
      feed_beat(W'(k), W_BASIC);
    end
    wait_done(c);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bubble_done: got %b want 1", out_valid); end
    n_cmp++; if (acc_out !== ACC_ONE) begin n_bad++; $display("FAIL bubble_acc: got %h want %h", acc_out, ACC_ONE); end
    for (int h = 0; h < 5; h++) begin
      step();
      n_cmp++;
      if (out_valid !== 1'b1 || acc_out !== ACC_ONE) begin
        n_bad++; $display("FAIL hold_stable: cycle %0d got valid=%b acc=%h want 1 %h", h, out_valid, acc_out, ACC_ONE);
      end
    end
    out_ready = 1'b1;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL busy_before_hs: got %b want 1", busy); end
    step();
    out_ready = 1'b0;
    n_cmp++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL after_hs: got busy=%b valid=%b want 0 0", busy, out_valid); end
  endtask

  task automatic test_saturation();
    int c;
    start_job(8'd4, 1'b0);
    for (int k = 0; k < 4; k++) feed_beat(8'd127, W_MAX);
    wait_done(c);
    n_cmp++; if (acc_out !== ACC_SAT) begin n_bad++; $display("FAIL sat_clamp: got %h want %h", acc_out, ACC_SAT); end
    n_cmp++; if (acc_out_w !== ACC_WRP) begin n_bad++; $display("FAIL sat_wrap: got %h want %h", acc_out_w, ACC_WRP); end
    finish_job();
  endtask

  task automatic run_basic(input logic keep);
    int c;
    start_job(8'd3, keep);
    for (int k = 1; k <= 3; k++) feed_beat(W'(k), W_BASIC);
    wait_done(c);
  endtask

  task automatic test_keep_acc();
    run_basic(1'b0);
    n_cmp++; if (acc_out !== ACC_ONE) begin n_bad++; $display("FAIL keep_job1: got %h want %h", acc_out, ACC_ONE); end
    finish_job();
    run_basic(1'b1);
    n_cmp++; if (acc_out !== ACC_TWO) begin n_bad++; $display("FAIL keep_job2: got %h want %h", acc_out, ACC_TWO); end
    finish_job();
    run_basic(1'b0);
    n_cmp++; if (acc_out !== ACC_ONE) begin n_bad++; $display("FAIL keep_job3: got %h want %h", acc_out, ACC_ONE); end
    finish_job();
  endtask

  task automatic test_len0_clear();
    int c;
    start_job(8'd0, 1'b0);
    n_cmp++; if (out_valid !== 1'b1 || acc_out !== '0) begin n_bad++; $display("FAIL len0_zero: got valid=%b acc=%h want 1 0", out_valid, acc_out); end
    finish_job();
    start_job(8'd3, 1'b0);
    feed_beat(8'd1, W_BASIC);
    clear_acc = 1'b1;
    feed_beat(8'd2, W_BASIC);
    feed_beat(8'd3, W_BASIC);
    clear_acc = 1'b0;
    wait_done(c);
    n_cmp++; if (acc_out !== ACC_ONE) begin n_bad++; $display("FAIL clear_in_run: got %h want %h", acc_out, ACC_ONE); end
    finish_job();
    start_job(8'd0, 1'b1);
    n_cmp++; if (out_valid !== 1'b1 || acc_out !== ACC_ONE) begin n_bad++; $display("FAIL len0_keep: got valid=%b acc=%h want 1 %h", out_valid, acc_out, ACC_ONE); end
    finish_job();
    clear_acc = 1'b1;
    step();
    clear_acc = 1'b0;
    n_cmp++; if (acc_out !== '0) begin n_bad++; $display("FAIL clear_idle: got %h want 0", acc_out); end
  endtask

  task automatic test_reset_midjob();
    start_job(8'd3, 1'b0);
    for (int k = 1; k <= 3; k++) feed_beat(W'(k), W_BASIC);
    step();
    n_cmp++; if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL drain_state: got busy=%b rdy=%b valid=%b want 1 0 0", busy, in_ready, out_valid); end
    rst = 1'b0;
    step();
    n_cmp++; if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_ctrl: got busy=%b rdy=%b valid=%b want 0 0 0", busy, in_ready, out_valid); end
    n_cmp++; if (acc_out !== '0 || lane_valid !== 4'b0) begin n_bad++; $display("FAIL midrst_data: got acc=%h lv=%b want 0 0000", acc_out, lane_valid); end
    rst = 1'b1;
    step();
    run_basic(1'b1);
    n_cmp++; if (acc_out !== ACC_ONE) begin n_bad++; $display("FAIL post_rst_job: got %h want %h", acc_out, ACC_ONE); end
    finish_job();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; start = 1'b0; len = '0; keep_acc = 1'b0; clear_acc = 1'b0;
    in_valid = 1'b0; a_in = '0; w_in = '0; out_ready = 1'b0;
    test_reset();
    test_basic();
    test_bubbles_backpressure();
    test_saturation();
    test_keep_acc();
    test_len0_clear();
    test_reset_midjob();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/systolic_layer_engine.md
# systolic_layer_engine

Parametrised successor to the fixed 4-lane MAC top level. A single sequencer FSM drives a systolic array of N_MACS skewed multiply-accumulate lanes. It computes one dot-product vector per job, y[j] = Σk a[k]·w[j][k], with j in 0..N_MACS-1 and k in 0..len-1. Operands arrive on a valid/ready stream, not from hard-wired memory files. Results are presented on a held output handshake, with optional saturation and cross-job accumulation.

## Interface
- W, 8, signed operand width (activations and weights)
- ACC_W, 16, signed accumulator width; must be ≥ 2·W
- N_MACS, 4, lane count, ≥ 1
- LEN_W, 8, width of the job length field
- SAT, 1, 1 = saturate accumulators on overflow; 0 = two's-complement wrap
- clk  input  1  sole clock; every flop is on the rising edge
- rst  input  1  reset; synchronous and active-low
- start  input  1  job request; sampled only in IDLE
- len  input  LEN_W  beats per job; latched on start
- keep_acc  input  1  latched on start; 1 = do not zero accumulators at job start
- clear_acc  input  1  zeros all accumulators; honoured only in IDLE
- in_valid  input  1  operand beat valid
- in_ready  output  1  engine accepts a beat
- a_in  input  W  signed activation, broadcast to all lanes
- w_in  input  N_MACS·W  packed signed weights; lane j uses bits [j·W +: W]
- out_valid  output  1  results held and stable
- out_ready  input  1  consumer accepts results
- acc_out  output  N_MACS·ACC_W  packed accumulators; lane j uses bits [j·ACC_W +: ACC_W]
- lane_valid  output  N_MACS  per-lane pulse; bit j high the cycle after lane j's accumulator updated
- busy  output  1  high whenever state ≠ IDLE

## Operation
- FSM states and transitions:
  - IDLE → RUN on start with len ≠ 0.
  - IDLE → DONE on start with len = 0.
  - RUN → DRAIN on the edge that accepts beat len.
  - DRAIN → DONE after N_MACS cycles.
  - DONE → IDLE on out_valid & out_ready.
- Job start: on accepting start, accumulators are zeroed unless keep_acc = 1. The beat counter resets to 0.
- in_ready = 1 only in RUN. A beat transfers on in_valid & in_ready. Bubbles (in_valid = 0) enter the skew chain as invalid slots and never update any accumulator.
- Skew: each transferred beat enters a chain. Lane j sees the beat j cycles after lane 0. Lane 0 registers its operand pair on the transfer edge. The weight slice for lane j travels with the beat, so lane j always multiplies a[k] by w[j][k].
- Arithmetic:
  - Product is signed W×W → 2·W, sign-extended to ACC_W + 1 bits and added to the accumulator.
  - SAT = 1: the result clamps to [−2^(ACC_W−1), 2^(ACC_W−1) − 1].
  - SAT = 0: the low ACC_W bits are kept.
- clear_acc in IDLE zeros all lanes on the next edge. In any other state it is ignored. If start and clear_acc arrive in the same IDLE cycle, the start-zeroing rule (keep_acc) governs.
- start outside IDLE is ignored; no queueing.
- acc_out always shows the live accumulators. It is stable throughout DONE.
- Reset mid-operation: next edge returns the FSM to IDLE and zeros accumulators, skew chain, beat counter and all outputs. Any in-flight job is discarded.

## Timing
- Reset values: in_ready = 0, out_valid = 0, busy = 0, lane_valid = 0, acc_out = 0.
- Beat transferred at edge c: lane j's accumulator updates at edge c + 1 + j, and lane_valid[j] is high during the following cycle.
- Last beat transferred at edge L: state is DRAIN for cycles L+1 … L+N_MACS. DONE is entered at edge L + N_MACS, the same edge lane N_MACS − 1 performs its final update. out_valid is high from that cycle onward.
- Minimum job latency, from start edge to out_valid, with no bubbles: 1 + len + N_MACS cycles.
- out_valid holds until out_ready is sampled high. busy deasserts the cycle after the handshake.
- len = 0: DONE on the edge after start. acc_out is 0, or the retained values when keep_acc = 1.

## Structure
- Shared package systolic_pkg:
  - state enum {IDLE, RUN, DRAIN, DONE}
  - a saturating-add function parameterised by ACC_W
  - a width-check constant (ACC_W ≥ 2·W)
- Sub-module systolic_mac_lane, instantiated N_MACS times via generate. Each instance holds one skew stage (valid, a, w), a multiply, a saturating accumulate, and a clear/zero input.
- The FSM, beat counter (LEN_W bits) and drain counter (clog2(N_MACS + 1) bits) live in the top module.

## Test plan
- Basic job: N_MACS = 4, len = 3, a = {1,2,3}, lane j weights all j+1, no bubbles. acc_out = {6,12,18,24}; out_valid exactly 1 + 3 + 4 cycles after start.
- Bubbles and backpressure: same data with in_valid low every other cycle, then out_ready held low 5 cycles. Results are identical; acc_out is stable while out_valid is held; busy drops the cycle after the handshake.
- Saturation: SAT = 1, ACC_W = 16, len = 4, a = 127, w = 127 on all lanes. acc_out lanes = 32767. With SAT = 0, lanes = 64516 mod 65536 read as signed = −1020.
- keep_acc chaining: job 1 as in the basic job, then job 2 with keep_acc = 1 and the same data. acc_out = {12,24,36,48}. A third job with keep_acc = 0 returns to {6,12,18,24}.
- len = 0 and clear: start with len = 0 and keep_acc = 0 gives out_valid next cycle with all zeros. clear_acc while in RUN is ignored; clear_acc in IDLE zeros all lanes.
- Reset mid-job: rst low during DRAIN. The next cycle shows IDLE, acc_out = 0, in_ready = 0, out_valid = 0. A following basic job produces correct results.
